// File: rtl/hazard_control_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_control_unit_if
// Bundles the pipeline-side signals of the hazard control unit.
//
// Signals:
//   id_rs1/id_rs2, id_uses_rs1/id_uses_rs2 : decode-stage operand info
//   ex_rd, ex_mem_read, ex_branch_taken     : execute-stage info
//   mem_req, mem_ready                      : data-memory status
//   pc_write_en .. mem_wb_bubble            : stage-register controls
//   halted                                  : core halted on memory timeout
//   stall_cnt/flush_cnt/freeze_cnt          : performance counters
//   dbg_state                               : sequencer state (0 RUN, 1 FREEZE, 2 HALT)
//
// Handshake: there is no valid/ready exchange on this bundle. Every input is a
// level sampled each cycle; every control output is valid in the same cycle
// as the inputs that produced it, and counters/state change on the clock edge.
//
// Modports: master = pipeline/environment side, slave = hazard control unit.
// -----------------------------------------------------------------------------
interface hazard_control_unit_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_write_en;
    logic             if_id_write_en;
    logic             if_id_flush;
    logic             id_ex_write_en;
    logic             id_ex_bubble;
    logic             ex_mem_write_en;
    logic             mem_wb_bubble;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] freeze_cnt;
    logic [1:0]       dbg_state;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_rd, ex_mem_read, ex_branch_taken,
        output mem_req, mem_ready,
        input  pc_write_en, if_id_write_en, if_id_flush,
        input  id_ex_write_en, id_ex_bubble, ex_mem_write_en, mem_wb_bubble,
        input  halted, stall_cnt, flush_cnt, freeze_cnt, dbg_state
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_rd, ex_mem_read, ex_branch_taken,
        input  mem_req, mem_ready,
        output pc_write_en, if_id_write_en, if_id_flush,
        output id_ex_write_en, id_ex_bubble, ex_mem_write_en, mem_wb_bubble,
        output halted, stall_cnt, flush_cnt, freeze_cnt, dbg_state
    );
endinterface

// File: rtl/hazard_control_unit.sv
// -----------------------------------------------------------------------------
// hazard_control_unit
// Pipeline sequencer for the 5-stage RV32I core. Produces stage-register
// enables, bubbles and flushes from load-use hazards, taken branches and
// data-memory busy; counts stall/flush/freeze cycles; halts the core when
// data memory stays busy for MEM_TIMEOUT consecutive cycles.
//
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : hazard_control_unit_if.slave (operand info in, controls/counters out)
//
// Parameters:
//   MEM_TIMEOUT : consecutive freeze cycles before HALT (1..65535)
//   CNT_W       : performance counter width
// -----------------------------------------------------------------------------
module hazard_control_unit #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst,
    hazard_control_unit_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FREEZE = 2'd1,
        ST_HALT   = 2'd2
    } state_t;

    // Timeout counter holds the number of freeze cycles already spent in the
    // current freeze episode; the cycle that finds it at TMO_LAST is the
    // MEM_TIMEOUT-th one and goes to HALT.
    localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

    state_t           r_state;
    logic [15:0]      r_tmo;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_freeze_cnt;

    logic w_freeze;
    logic w_load_use;
    logic w_branch;

    assign w_freeze   = bus.mem_req && !bus.mem_ready;
    assign w_branch   = bus.ex_branch_taken;
    assign w_load_use = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                        ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                         (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd)));

    // Control outputs are combinational so they act in the same cycle.
    always_comb begin
        bus.pc_write_en     = 1'b1;
        bus.if_id_write_en  = 1'b1;
        bus.if_id_flush     = 1'b0;
        bus.id_ex_write_en  = 1'b1;
        bus.id_ex_bubble    = 1'b0;
        bus.ex_mem_write_en = 1'b1;
        bus.mem_wb_bubble   = 1'b0;
        bus.halted          = 1'b0;
        if (rst) begin
            bus.pc_write_en     = 1'b0;
            bus.if_id_write_en  = 1'b0;
            bus.if_id_flush     = 1'b1;
            bus.id_ex_write_en  = 1'b0;
            bus.id_ex_bubble    = 1'b1;
            bus.ex_mem_write_en = 1'b0;
            bus.mem_wb_bubble   = 1'b1;
        end else if (r_state == ST_HALT) begin
            bus.pc_write_en     = 1'b0;
            bus.if_id_write_en  = 1'b0;
            bus.id_ex_write_en  = 1'b0;
            bus.id_ex_bubble    = 1'b1;
            bus.ex_mem_write_en = 1'b0;
            bus.mem_wb_bubble   = 1'b1;
            bus.halted          = 1'b1;
        end else if (w_freeze) begin
            // Everything holds; MEM/WB gets a NOP since the access is unfinished.
            bus.pc_write_en     = 1'b0;
            bus.if_id_write_en  = 1'b0;
            bus.id_ex_write_en  = 1'b0;
            bus.ex_mem_write_en = 1'b0;
            bus.mem_wb_bubble   = 1'b1;
        end else if (w_branch) begin
            // Decode and fetch hold wrong-path instructions: squash both.
            bus.if_id_flush  = 1'b1;
            bus.id_ex_bubble = 1'b1;
        end else if (w_load_use) begin
            // One stall cycle; forwarding from MEM covers the next cycle.
            bus.pc_write_en    = 1'b0;
            bus.if_id_write_en = 1'b0;
            bus.id_ex_bubble   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_tmo        <= 16'd0;
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_freeze_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN, ST_FREEZE: begin
                    if (w_freeze) begin
                        r_freeze_cnt <= r_freeze_cnt + CNT_W'(1);
                        if (r_tmo == TMO_LAST) begin
                            r_state <= ST_HALT;
                            r_tmo   <= 16'd0;
                        end else begin
                            r_state <= ST_FREEZE;
                            r_tmo   <= r_tmo + 16'd1;
                        end
                    end else begin
                        r_state <= ST_RUN;
                        r_tmo   <= 16'd0;
                        if (w_branch) begin
                            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
                        end else if (w_load_use) begin
                            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_RUN;
                    r_tmo   <= 16'd0;
                end
            endcase
        end
    end

    assign bus.stall_cnt  = r_stall_cnt;
    assign bus.flush_cnt  = r_flush_cnt;
    assign bus.freeze_cnt = r_freeze_cnt;
    assign bus.dbg_state  = r_state;
endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
Pipeline sequencer for the 5-stage RV32I core. Sits beside the decode stage and drives the stage-register enables, bubbles and flushes for the whole pipeline. Detects load-use hazards on the decode operands, squashes wrong-path instructions on a taken branch, and freezes the pipeline while data memory is busy. Also counts stall, flush and freeze cycles, and halts the core on a data-memory timeout.

Parameters:
MEM_TIMEOUT, 64, maximum consecutive freeze cycles before entering HALT (valid range 1..65535)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
id_rs1  in  5  rs1 field of the instruction in decode
id_rs2  in  5  rs2 field of the instruction in decode
id_uses_rs1  in  1  decode instruction reads rs1
id_uses_rs2  in  1  decode instruction reads rs2
ex_rd  in  5  destination register of the instruction in execute
ex_mem_read  in  1  instruction in execute is a load
ex_branch_taken  in  1  branch/jump resolved taken in execute
mem_req  in  1  memory stage has an outstanding data-memory access
mem_ready  in  1  data memory completes the access this cycle
pc_write_en  out  1  PC register update enable
if_id_write_en  out  1  IF/ID register enable
if_id_flush  out  1  clear IF/ID to NOP
id_ex_write_en  out  1  ID/EX register enable
id_ex_bubble  out  1  load NOP control into ID/EX
ex_mem_write_en  out  1  EX/MEM register enable
mem_wb_bubble  out  1  load NOP control into MEM/WB
halted  out  1  FSM in HALT
stall_cnt  out  CNT_W  load-use stall cycles
flush_cnt  out  CNT_W  taken-branch flushes
freeze_cnt  out  CNT_W  memory freeze cycles

Behaviour:
- Reset:
  - The state register clears to RUN on the edge where rst=1.
  - The counters and the timeout counter clear to 0.
  - While rst=1, outputs are forced to: all *_write_en=0, id_ex_bubble=1, mem_wb_bubble=1, if_id_flush=1, halted=0.
- Control outputs are combinational from state and inputs, so they take effect in the same cycle. Counters and state update on the clock edge.
- Conditions:
  - freeze = mem_req && !mem_ready
  - load_use = ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd))
- Default outputs in RUN with no condition active:
  - every *_write_en=1
  - bubbles and flush = 0
- Priority when several conditions are active: freeze > branch > load_use.
- Freeze, in RUN or FREEZE state:
  - all *_write_en=0, mem_wb_bubble=1, other bubbles and flush = 0.
  - freeze_cnt increments by 1.
  - FSM goes to FREEZE.
  - A branch or load_use in the same cycle is ignored. Because the EX/ID contents are held, those conditions are re-evaluated once the freeze ends.
- Branch (ex_branch_taken=1, no freeze):
  - pc_write_en=1, if_id_flush=1, id_ex_bubble=1, remaining enables=1.
  - flush_cnt increments by 1.
  - load_use is ignored in this cycle, since the decode instruction is on the wrong path.
- Load-use (no freeze, no branch):
  - pc_write_en=0, if_id_write_en=0, id_ex_bubble=1, ex_mem_write_en=1, id_ex_write_en=1.
  - stall_cnt increments by 1.
  - Exactly one stall cycle per hazard; no extra state. MEM-to-EX forwarding covers the following cycle.
  - x0 never causes a stall.
- FSM:
  - RUN -> FREEZE on freeze.
  - FREEZE -> RUN on the first cycle where freeze=0. That cycle is evaluated with RUN rules.
  - FREEZE stays in FREEZE while freeze=1, incrementing the timeout counter. The counter clears on any exit.
  - FREEZE -> HALT when the timeout counter reaches MEM_TIMEOUT-1 and freeze is still 1. HALT is therefore entered after exactly MEM_TIMEOUT consecutive freeze cycles.
  - HALT: all *_write_en=0, both bubbles=1, if_id_flush=0, halted=1, counters frozen. Only rst exits HALT.
- Counters wrap modulo 2^CNT_W.
- Reset asserted mid-freeze or in HALT returns to RUN on the next edge. Any pending hazard is dropped.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 for 1 cycle, then ex_mem_read=0 -> cycle 0: pc_write_en=0, if_id_write_en=0, id_ex_bubble=1; cycle 1: all enables 1; stall_cnt=1.
- x0 / unused operand: ex_mem_read=1, ex_rd=0, id_rs1=0; then ex_rd=7, id_rs1=7, id_uses_rs1=0 -> no stall in either cycle, stall_cnt=0.
- Branch plus load-use in the same cycle: ex_branch_taken=1 with the load-use condition true -> if_id_flush=1, id_ex_bubble=1, pc_write_en=1; flush_cnt=1, stall_cnt=0.
- Freeze with branch: mem_req=1, mem_ready=0 for 3 cycles with ex_branch_taken=1, then mem_ready=1 -> 3 cycles with all enables 0 and mem_wb_bubble=1, freeze_cnt=3; the branch flush occurs on cycle 3; flush_cnt=1.
- Timeout with MEM_TIMEOUT=4: mem_req=1, mem_ready=0 held -> halted=1 after the 4th freeze edge; enables stay 0 while mem_ready pulses; rst for 1 cycle -> halted=0, counters 0, state RUN.
- Reset mid-freeze: rst during the 2nd freeze cycle -> during rst, enables 0 and bubbles/flush 1; after rst with mem_req=0, all enables 1 and freeze_cnt=0.
